// File: rtl/sw_encoder.sv
// sw_encoder -- debounced 4-to-2 priority encoder for board slide switches.
//
// Each raw switch is passed through a two-flop synchronizer and an
// independent debouncer. The debounced vector is priority-encoded, with the
// highest-numbered active switch winning. The result is registered together
// with a one-cycle strobe that marks every change of {valid, multi, code}.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles a synchronized switch must disagree
//                    with its stable value before it is accepted (2..65535)
// Ports:
//   clk     system clock, all state on the rising edge
//   rst_n   asynchronous active-low reset
//   sw      raw asynchronous switch inputs
//   code    index of the highest set debounced switch (0 when none)
//   valid   any debounced switch is high
//   multi   two or more debounced switches are high
//   strobe  one-cycle pulse whenever {valid, multi, code} changes
module sw_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic [1:0] code,
  output logic       valid,
  output logic       multi,
  output logic       strobe
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] stable_vec;

  logic [1:0] code_next;
  logic       valid_next;
  logic       multi_next;

  logic [1:0] code_reg;
  logic       valid_reg;
  logic       multi_reg;
  logic       strobe_reg;

  // Two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw;
      sync2_reg <= sync1_reg;
    end
  end

  // One debouncer per switch. Any cycle where the synchronized input agrees
  // with the stable value clears the counter, so a short glitch never
  // accumulates. The counter reaches DEBOUNCE_CYCLES-1 and then commits the
  // new value instead of wrapping.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic          stable_bit_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stable_bit_reg <= 1'b0;
          cnt_reg        <= '0;
        end else if (sync2_reg[gi] == stable_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          stable_bit_reg <= sync2_reg[gi];
          cnt_reg        <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      assign stable_vec[gi] = stable_bit_reg;
    end
  endgenerate

  // Priority encode; x & (x-1) clears the lowest set bit, so it is nonzero
  // exactly when at least two bits are set.
  always_comb begin
    code_next = 2'd0;
    if (stable_vec[3])      code_next = 2'd3;
    else if (stable_vec[2]) code_next = 2'd2;
    else if (stable_vec[1]) code_next = 2'd1;
    valid_next = |stable_vec;
    multi_next = (stable_vec & (stable_vec - 4'd1)) != 4'd0;
  end

  // Output registers. The strobe compares the incoming value against what is
  // currently presented, so it is high for exactly the cycle in which the
  // new value first appears. Reset clears both sides, so releasing reset
  // never produces a strobe on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg   <= 2'd0;
      valid_reg  <= 1'b0;
      multi_reg  <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      code_reg   <= code_next;
      valid_reg  <= valid_next;
      multi_reg  <= multi_next;
      strobe_reg <= {valid_next, multi_next, code_next} != {valid_reg, multi_reg, code_reg};
    end
  end

  assign code   = code_reg;
  assign valid  = valid_reg;
  assign multi  = multi_reg;
  assign strobe = strobe_reg;

endmodule

// File: tb/tb_sw_encoder.sv
// tb_sw_encoder -- directed bench for sw_encoder.
//
// Two instances: one with DEBOUNCE_CYCLES=4 for most scenarios and one with
// the default of 16 for the latency check at the default setting. Edge
// numbers are counted from E0, the first rising edge that samples a new sw
// value (or the first edge after reset release).
module tb_sw_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw4;
  logic [3:0] sw16;

  logic [1:0] code4, code16;
  logic       valid4, valid16;
  logic       multi4, multi16;
  logic       strobe4, strobe16;

  always #5 clk = ~clk;

  sw_encoder #(.DEBOUNCE_CYCLES(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw4),
    .code   (code4),
    .valid  (valid4),
    .multi  (multi4),
    .strobe (strobe4)
  );

  sw_encoder dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw16),
    .code   (code16),
    .valid  (valid16),
    .multi  (multi16),
    .strobe (strobe16)
  );

  // Selects which instance the observer follows.
  logic       sel16 = 1'b0;
  logic [1:0] obs_code;
  logic       obs_valid;
  logic       obs_multi;
  logic       obs_strobe;

  always_comb begin
    obs_code   = sel16 ? code16   : code4;
    obs_valid  = sel16 ? valid16  : valid4;
    obs_multi  = sel16 ? multi16  : multi4;
    obs_strobe = sel16 ? strobe16 : strobe4;
  end

  int n_total = 0;
  int n_pass  = 0;

  // Edge counter and strobe log: each strobe seen at a falling edge is logged
  // with the number of the rising edge that produced it.
  int edge_cnt = 0;
  int strobes[$];
  int mark   = 0;
  int qstart = 0;

  always @(posedge clk) edge_cnt++;
  always @(negedge clk) if (obs_strobe) strobes.push_back(edge_cnt);

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Call at posedge+1 just before changing the stimulus; the next rising
  // edge becomes E0.
  task automatic start();
    mark   = edge_cnt;
    qstart = strobes.size();
  endtask

  // Wait until edge E(n_edges) has passed, then check the strobes logged
  // since start() and the final output state.
  task automatic expect_txn(input string tag, input int n_edges, input int exp_cnt,
                            input int exp_e1, input int exp_e2,
                            input int exp_code, input int exp_valid, input int exp_multi);
    int cnt;
    int e1;
    int e2;
    while (edge_cnt < mark + 1 + n_edges) @(posedge clk);
    @(negedge clk);
    #1;
    cnt = strobes.size() - qstart;
    e1  = (cnt >= 1) ? strobes[qstart] - mark - 1 : -1;
    e2  = (cnt >= 2) ? strobes[qstart + 1] - mark - 1 : -1;
    check({tag, ".nstrobe"}, cnt, exp_cnt);
    if (exp_cnt >= 1) check({tag, ".edge1"}, e1, exp_e1);
    if (exp_cnt >= 2) check({tag, ".edge2"}, e2, exp_e2);
    check({tag, ".code"},   int'(obs_code),   exp_code);
    check({tag, ".valid"},  int'(obs_valid),  exp_valid);
    check({tag, ".multi"},  int'(obs_multi),  exp_multi);
    check({tag, ".strobe"}, int'(obs_strobe), 0);
    $display("txn %-12s strobes=%0d first=E%0d second=E%0d code=%0d valid=%0b multi=%0b",
             tag, cnt, e1, e2, obs_code, obs_valid, obs_multi);
  endtask

  initial begin
    rst_n = 1'b0;
    sw4   = 4'b1111;
    sw16  = 4'b0000;

    // Held in reset: everything at zero in both instances.
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold4",  int'({code4, valid4, multi4, strobe4}), 0);
    check("rst_hold16", int'({code16, valid16, multi16, strobe16}), 0);

    // Release with all switches already high: one strobe at E6, none at release.
    start();
    rst_n = 1'b1;
    expect_txn("rst_release", 12, 1, 6, 0, 3, 1, 1);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", int'({code4, valid4, multi4, strobe4}), 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_async_hold", int'({code4, valid4, multi4, strobe4}), 0);
    start();
    rst_n = 1'b1;
    expect_txn("rst_again", 12, 1, 6, 0, 3, 1, 1);

    // Reset asserted mid-debounce discards the partial count.
    @(posedge clk);
    #1;
    sw4 = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_deb", int'({code4, valid4, multi4, strobe4}), 0);
    @(posedge clk);
    #1;
    start();
    rst_n = 1'b1;
    expect_txn("rst_mid_rel", 12, 0, 0, 0, 0, 0, 0);

    // Single switch: 0000 -> 0100.
    start();
    sw4 = 4'b0100;
    expect_txn("single_sw2", 12, 1, 6, 0, 2, 1, 0);

    // Back to zero.
    start();
    sw4 = 4'b0000;
    expect_txn("clear", 12, 1, 6, 0, 0, 0, 0);

    // Glitch of 3 cycles on sw[1] is rejected.
    start();
    sw4 = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    sw4 = 4'b0000;
    expect_txn("glitch3", 20, 0, 0, 0, 0, 0, 0);

    // A 6-cycle pulse gets through: rise at E6, fall at E12.
    start();
    sw4 = 4'b0010;
    repeat (6) @(posedge clk);
    #1;
    sw4 = 4'b0000;
    expect_txn("pulse6", 20, 2, 6, 12, 0, 0, 0);

    // Priority and multi-hot.
    start();
    sw4 = 4'b1011;
    expect_txn("prio_1011", 12, 1, 6, 0, 3, 1, 1);

    start();
    sw4 = 4'b0001;
    expect_txn("to_0001", 12, 1, 6, 0, 0, 1, 0);

    // Release to empty, then a long quiet hold.
    start();
    sw4 = 4'b0000;
    expect_txn("to_empty", 12, 1, 6, 0, 0, 0, 0);

    start();
    expect_txn("quiet100", 100, 0, 0, 0, 0, 0, 0);

    // Default debounce length: strobe exactly at E18.
    @(posedge clk);
    #1;
    sel16 = 1'b1;
    start();
    sw16 = 4'b1000;
    expect_txn("deb16", 30, 1, 18, 0, 3, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
